// File: rtl/idu1_scoreboard.sv
//------------------------------------------------------------------------------
// idu1_scoreboard
//
// Register scoreboard for the IDU1 issue stage. It tracks destination
// registers of in-flight multi-cycle operations (MUL/DIV/LSU/MAC), stalls
// issue on RAW/WAW hazards against them, retires entries from the EXU
// writeback port, flags writeback bypass for operands whose producer writes
// back this cycle, and caps the number of outstanding long operations.
//
// Parameters
//   MAX_OUTSTANDING  maximum in-flight long operations (legal 1..7)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   iss_valid                      IDU1 holds an instruction requesting issue
//   iss_rs1_addr/iss_rs1_en        source 1 address / operand is read
//   iss_rs2_addr/iss_rs2_en        source 2 address / operand is read
//   iss_rd_addr/iss_rd_wr_en       destination address / instruction writes rd
//   iss_long                       instruction has multi-cycle writeback
//   exu_wb_rd_addr                 EXU writeback address
//   exu_wb_rd_wr_en                EXU writeback valid
//   exu_wb_long                    writeback comes from a long unit
//   iss_stall                      hold the instruction in IDU1 this cycle
//   iss_fire                       iss_valid & ~iss_stall
//   fwd_rs1/fwd_rs2                take operand from the writeback bus
//   sb_pending                     per-register pending bits (bit 0 always 0)
//   sb_outstanding                 in-flight long operation count
//   sb_err                         sticky protocol-error flag
//------------------------------------------------------------------------------
module idu1_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs1_addr,
    input  logic [4:0]  iss_rs2_addr,
    input  logic        iss_rs1_en,
    input  logic        iss_rs2_en,
    input  logic [4:0]  iss_rd_addr,
    input  logic        iss_rd_wr_en,
    input  logic        iss_long,
    input  logic [4:0]  exu_wb_rd_addr,
    input  logic        exu_wb_rd_wr_en,
    input  logic        exu_wb_long,
    output logic        iss_stall,
    output logic        iss_fire,
    output logic        fwd_rs1,
    output logic        fwd_rs2,
    output logic [31:0] sb_pending,
    output logic [2:0]  sb_outstanding,
    output logic        sb_err
);

    localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

    // Registered state
    logic [31:0] pending_q, pending_d;
    logic [2:0]  count_q,   count_d;
    logic        err_q,     err_d;

    // Writeback decode
    logic long_retire;
    logic clr_rs1, clr_rs2, clr_rd;

    // Hazard terms
    logic raw_rs1, raw_rs2, waw, full;

    // Update terms
    logic tracked;
    logic count_inc, count_dec;
    logic retire_err;

    //--------------------------------------------------------------------------
    // Writeback decode: a long retire frees its register in the same cycle,
    // so a dependent instruction can issue with the value bypassed.
    //--------------------------------------------------------------------------
    always_comb begin
        long_retire = exu_wb_rd_wr_en & exu_wb_long;
        clr_rs1     = long_retire & (exu_wb_rd_addr == iss_rs1_addr);
        clr_rs2     = long_retire & (exu_wb_rd_addr == iss_rs2_addr);
        clr_rd      = long_retire & (exu_wb_rd_addr == iss_rd_addr);
    end

    //--------------------------------------------------------------------------
    // Hazard detection and issue handshake
    //--------------------------------------------------------------------------
    always_comb begin
        raw_rs1 = iss_rs1_en & (iss_rs1_addr != 5'd0)
                & pending_q[iss_rs1_addr] & ~clr_rs1;
        raw_rs2 = iss_rs2_en & (iss_rs2_addr != 5'd0)
                & pending_q[iss_rs2_addr] & ~clr_rs2;
        waw     = iss_rd_wr_en & (iss_rd_addr != 5'd0)
                & pending_q[iss_rd_addr] & ~clr_rd;
        // A retire in the same cycle deliberately gives no relief here: the
        // full check looks only at the registered count.
        full    = iss_long & (count_q == MaxCnt);

        iss_stall = iss_valid & (raw_rs1 | raw_rs2 | waw | full);
        iss_fire  = iss_valid & ~iss_stall;
    end

    //--------------------------------------------------------------------------
    // Writeback bypass: any writeback (ALU or long) to a read source register,
    // independent of stall.
    //--------------------------------------------------------------------------
    always_comb begin
        fwd_rs1 = iss_valid & iss_rs1_en & (iss_rs1_addr != 5'd0)
                & exu_wb_rd_wr_en & (exu_wb_rd_addr == iss_rs1_addr);
        fwd_rs2 = iss_valid & iss_rs2_en & (iss_rs2_addr != 5'd0)
                & exu_wb_rd_wr_en & (exu_wb_rd_addr == iss_rs2_addr);
    end

    //--------------------------------------------------------------------------
    // Pending vector next state: clear first, then set, so a simultaneous
    // set and clear of the same register leaves it pending.
    //--------------------------------------------------------------------------
    always_comb begin
        tracked   = iss_fire & iss_long & iss_rd_wr_en & (iss_rd_addr != 5'd0);

        pending_d = pending_q;
        if (long_retire) begin
            pending_d[exu_wb_rd_addr] = 1'b0;
        end
        if (tracked) begin
            pending_d[iss_rd_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    //--------------------------------------------------------------------------
    // Outstanding count: saturates at MaxCnt on increment and at zero on
    // decrement; +1 and -1 in the same cycle cancel.
    //--------------------------------------------------------------------------
    always_comb begin
        count_inc = iss_fire & iss_long & (count_q != MaxCnt);
        count_dec = long_retire & (count_q != 3'd0);

        unique case ({count_inc, count_dec})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    //--------------------------------------------------------------------------
    // Protocol error: retire of a register that is not pending, or a retire
    // with nothing outstanding. Sticky until reset.
    //--------------------------------------------------------------------------
    always_comb begin
        retire_err = long_retire
                   & (((exu_wb_rd_addr != 5'd0) & ~pending_q[exu_wb_rd_addr])
                      | (count_q == 3'd0));
        err_d      = err_q | retire_err;
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign sb_pending     = pending_q;
    assign sb_outstanding = count_q;
    assign sb_err         = err_q;

endmodule

// File: tb/tb_idu1_scoreboard.sv
module tb_idu1_scoreboard;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs1_addr;
    logic [4:0]  iss_rs2_addr;
    logic        iss_rs1_en;
    logic        iss_rs2_en;
    logic [4:0]  iss_rd_addr;
    logic        iss_rd_wr_en;
    logic        iss_long;
    logic [4:0]  exu_wb_rd_addr;
    logic        exu_wb_rd_wr_en;
    logic        exu_wb_long;
    logic        iss_stall;
    logic        iss_fire;
    logic        fwd_rs1;
    logic        fwd_rs2;
    logic [31:0] sb_pending;
    logic [2:0]  sb_outstanding;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    idu1_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk             (clk),
        .rst             (rst),
        .iss_valid       (iss_valid),
        .iss_rs1_addr    (iss_rs1_addr),
        .iss_rs2_addr    (iss_rs2_addr),
        .iss_rs1_en      (iss_rs1_en),
        .iss_rs2_en      (iss_rs2_en),
        .iss_rd_addr     (iss_rd_addr),
        .iss_rd_wr_en    (iss_rd_wr_en),
        .iss_long        (iss_long),
        .exu_wb_rd_addr  (exu_wb_rd_addr),
        .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
        .exu_wb_long     (exu_wb_long),
        .iss_stall       (iss_stall),
        .iss_fire        (iss_fire),
        .fwd_rs1         (fwd_rs1),
        .fwd_rs2         (fwd_rs2),
        .sb_pending      (sb_pending),
        .sb_outstanding  (sb_outstanding),
        .sb_err          (sb_err)
    );

    // ---------------------------------------------------------------- helpers
    task automatic idle_inputs();
        iss_valid       = 1'b0;
        iss_rs1_addr    = 5'd0;
        iss_rs2_addr    = 5'd0;
        iss_rs1_en      = 1'b0;
        iss_rs2_en      = 1'b0;
        iss_rd_addr     = 5'd0;
        iss_rd_wr_en    = 1'b0;
        iss_long        = 1'b0;
        exu_wb_rd_addr  = 5'd0;
        exu_wb_rd_wr_en = 1'b0;
        exu_wb_long     = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        iss_valid    = 1'b1;
        iss_long     = 1'b1;
        iss_rd_wr_en = 1'b1;
        iss_rd_addr  = rd;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_dut();
        n_tests++;
        if (sb_pending !== 32'h0) begin
            n_fail++; $display("FAIL reset_pending: got %h want %h", sb_pending, 32'h0);
        end
        n_tests++;
        if (sb_outstanding !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", sb_outstanding);
        end
        n_tests++;
        if (sb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", sb_err);
        end
        #1;
        n_tests++;
        if ({iss_stall, iss_fire, fwd_rs1, fwd_rs2} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_comb: got %b want 0000", {iss_stall, iss_fire, fwd_rs1, fwd_rs2});
        end
        iss_valid = 1'b1; iss_rs1_addr = 5'd5; iss_rs1_en = 1'b1;
        iss_rd_addr = 5'd6; iss_rd_wr_en = 1'b1; iss_long = 1'b0;
        #1;
        n_tests++;
        if ({iss_stall, iss_fire} !== 2'b01) begin
            n_fail++; $display("FAIL reset_issue: stall/fire got %b want 01", {iss_stall, iss_fire});
        end
        tick();
        n_tests++;
        if (sb_pending !== 32'h0 || sb_outstanding !== 3'd0) begin
            n_fail++; $display("FAIL reset_alu_issue: pending %h count %0d want 0/0", sb_pending, sb_outstanding);
        end
        idle_inputs();
    endtask

    task automatic test_raw_mul();
        reset_dut();
        issue_long(5'd7);
        #1;
        n_tests++;
        if (iss_fire !== 1'b1) begin
            n_fail++; $display("FAIL raw_first_fire: got %b want 1", iss_fire);
        end
        tick();
        n_tests++;
        if (sb_pending[7] !== 1'b1 || sb_outstanding !== 3'd1) begin
            n_fail++; $display("FAIL raw_set: pending[7] %b count %0d want 1/1", sb_pending[7], sb_outstanding);
        end
        idle_inputs();
        iss_valid = 1'b1; iss_rs2_addr = 5'd7; iss_rs2_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if ({iss_stall, iss_fire} !== 2'b10) begin
                n_fail++; $display("FAIL raw_stall[%0d]: stall/fire got %b want 10", c, {iss_stall, iss_fire});
            end
            tick();
        end
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1; exu_wb_rd_addr = 5'd7;
        #1;
        n_tests++;
        if ({iss_stall, iss_fire, fwd_rs2} !== 3'b011) begin
            n_fail++; $display("FAIL raw_release: stall/fire/fwd2 got %b want 011", {iss_stall, iss_fire, fwd_rs2});
        end
        tick();
        n_tests++;
        if (sb_pending[7] !== 1'b0 || sb_outstanding !== 3'd0 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL raw_clear: pending[7] %b count %0d err %b want 0/0/0", sb_pending[7], sb_outstanding, sb_err);
        end
        idle_inputs();
    endtask

    task automatic test_waw_setclr();
        reset_dut();
        issue_long(5'd9);
        tick();
        idle_inputs();
        issue_long(5'd9);
        #1;
        n_tests++;
        if ({iss_stall, iss_fire} !== 2'b10) begin
            n_fail++; $display("FAIL waw_stall: stall/fire got %b want 10", {iss_stall, iss_fire});
        end
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1; exu_wb_rd_addr = 5'd9;
        #1;
        n_tests++;
        if (iss_fire !== 1'b1) begin
            n_fail++; $display("FAIL waw_setclr_fire: got %b want 1", iss_fire);
        end
        tick();
        n_tests++;
        if (sb_pending !== 32'h0000_0200 || sb_outstanding !== 3'd1 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL waw_setclr_state: pending %h count %0d err %b want 00000200/1/0", sb_pending, sb_outstanding, sb_err);
        end
        idle_inputs();
    endtask

    task automatic test_capacity();
        logic [4:0] rd;
        reset_dut();
        for (int i = 1; i <= 4; i++) begin
            rd = 5'(i);
            issue_long(rd);
            #1;
            n_tests++;
            if (iss_fire !== 1'b1) begin
                n_fail++; $display("FAIL cap_fill_fire[%0d]: got %b want 1", i, iss_fire);
            end
            tick();
        end
        n_tests++;
        if (sb_outstanding !== 3'd4 || sb_pending !== 32'h0000_001E) begin
            n_fail++; $display("FAIL cap_full: count %0d pending %h want 4/0000001e", sb_outstanding, sb_pending);
        end
        issue_long(5'd10);
        #1;
        n_tests++;
        if (iss_stall !== 1'b1) begin
            n_fail++; $display("FAIL cap_stall: got %b want 1", iss_stall);
        end
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1; exu_wb_rd_addr = 5'd1;
        #1;
        n_tests++;
        if ({iss_stall, iss_fire} !== 2'b10) begin
            n_fail++; $display("FAIL cap_no_relief: stall/fire got %b want 10", {iss_stall, iss_fire});
        end
        tick();
        n_tests++;
        if (sb_outstanding !== 3'd3 || sb_pending[1] !== 1'b0) begin
            n_fail++; $display("FAIL cap_retire: count %0d pending[1] %b want 3/0", sb_outstanding, sb_pending[1]);
        end
        exu_wb_rd_wr_en = 1'b0; exu_wb_long = 1'b0;
        #1;
        n_tests++;
        if ({iss_stall, iss_fire} !== 2'b01) begin
            n_fail++; $display("FAIL cap_fire_after: stall/fire got %b want 01", {iss_stall, iss_fire});
        end
        tick();
        n_tests++;
        if (sb_outstanding !== 3'd4 || sb_pending[10] !== 1'b1) begin
            n_fail++; $display("FAIL cap_refill: count %0d pending[10] %b want 4/1", sb_outstanding, sb_pending[10]);
        end
        idle_inputs();
    endtask

    task automatic test_x0_alu_bypass();
        reset_dut();
        issue_long(5'd0);
        #1;
        n_tests++;
        if (iss_fire !== 1'b1) begin
            n_fail++; $display("FAIL x0_fire: got %b want 1", iss_fire);
        end
        tick();
        n_tests++;
        if (sb_pending !== 32'h0 || sb_outstanding !== 3'd1) begin
            n_fail++; $display("FAIL x0_state: pending %h count %0d want 0/1", sb_pending, sb_outstanding);
        end
        idle_inputs();
        iss_valid = 1'b1; iss_rs1_addr = 5'd3; iss_rs1_en = 1'b1;
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b0; exu_wb_rd_addr = 5'd3;
        #1;
        n_tests++;
        if ({fwd_rs1, iss_stall, fwd_rs2} !== 3'b100) begin
            n_fail++; $display("FAIL alu_bypass: fwd1/stall/fwd2 got %b want 100", {fwd_rs1, iss_stall, fwd_rs2});
        end
        tick();
        n_tests++;
        if (sb_outstanding !== 3'd1 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL alu_wb_no_retire: count %0d err %b want 1/0", sb_outstanding, sb_err);
        end
        idle_inputs();
    endtask

    task automatic test_errors();
        reset_dut();
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1; exu_wb_rd_addr = 5'd12;
        tick();
        idle_inputs();
        n_tests++;
        if (sb_err !== 1'b1 || sb_outstanding !== 3'd0) begin
            n_fail++; $display("FAIL err_set: err %b count %0d want 1/0", sb_err, sb_outstanding);
        end
        tick(); tick(); tick();
        n_tests++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", sb_err);
        end
        reset_dut();
        n_tests++;
        if (sb_err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset: got %b want 0", sb_err);
        end
        // Retire to x0 with nothing outstanding: only the underflow rule applies.
        exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1; exu_wb_rd_addr = 5'd0;
        tick();
        idle_inputs();
        n_tests++;
        if (sb_err !== 1'b1 || sb_outstanding !== 3'd0) begin
            n_fail++; $display("FAIL err_underflow: err %b count %0d want 1/0", sb_err, sb_outstanding);
        end
    endtask

    // Randomised traffic against a set/counter model. The bench plays the
    // EXU: it retires previously fired long ops in arbitrary order, mixes in
    // ALU writebacks, and occasionally injects a spurious retire or a reset.
    task automatic test_random();
        bit          m_pend[32];
        int          m_cnt;
        bit          m_err;
        logic [4:0]  inflight[$];
        bit          retire, e_stall, e_fire, e_f1, e_f2, inc, dec;
        logic [31:0] e_vec;
        int          r, idx;

        reset_dut();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);

            r = $urandom_range(0, 99);
            if (r < 40 && inflight.size() > 0) begin
                idx = $urandom_range(0, inflight.size() - 1);
                exu_wb_rd_addr = inflight[idx];
                inflight.delete(idx);
                exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1;
            end else if (r < 42) begin
                exu_wb_rd_addr = 5'($urandom_range(0, 31));
                exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b1;
            end else if (r < 72) begin
                exu_wb_rd_addr = 5'($urandom_range(0, 7));
                exu_wb_rd_wr_en = 1'b1; exu_wb_long = 1'b0;
            end else begin
                exu_wb_rd_addr = 5'($urandom_range(0, 31));
                exu_wb_rd_wr_en = 1'b0; exu_wb_long = 1'($urandom_range(0, 1));
            end

            iss_valid    = ($urandom_range(0, 3) != 0);
            iss_rs1_addr = 5'($urandom_range(0, 7));
            iss_rs2_addr = 5'($urandom_range(0, 7));
            iss_rs1_en   = 1'($urandom_range(0, 1));
            iss_rs2_en   = 1'($urandom_range(0, 1));
            iss_rd_addr  = 5'($urandom_range(0, 7));
            iss_long     = 1'($urandom_range(0, 1));
            iss_rd_wr_en = iss_long ? 1'b1 : 1'($urandom_range(0, 1));

            // Expected combinational outputs.
            retire  = exu_wb_rd_wr_en && exu_wb_long;
            e_stall = iss_valid && (
                (iss_rs1_en && iss_rs1_addr != 0 && m_pend[iss_rs1_addr]
                    && !(retire && exu_wb_rd_addr == iss_rs1_addr)) ||
                (iss_rs2_en && iss_rs2_addr != 0 && m_pend[iss_rs2_addr]
                    && !(retire && exu_wb_rd_addr == iss_rs2_addr)) ||
                (iss_rd_wr_en && iss_rd_addr != 0 && m_pend[iss_rd_addr]
                    && !(retire && exu_wb_rd_addr == iss_rd_addr)) ||
                (iss_long && m_cnt == MAXO));
            e_fire  = iss_valid && !e_stall;
            e_f1    = iss_valid && iss_rs1_en && iss_rs1_addr != 0
                      && exu_wb_rd_wr_en && exu_wb_rd_addr == iss_rs1_addr;
            e_f2    = iss_valid && iss_rs2_en && iss_rs2_addr != 0
                      && exu_wb_rd_wr_en && exu_wb_rd_addr == iss_rs2_addr;

            #1;
            n_tests++;
            if ({iss_stall, iss_fire, fwd_rs1, fwd_rs2} !== {e_stall, e_fire, e_f1, e_f2}) begin
                n_fail++;
                $display("FAIL rand_comb cyc %0d: stall/fire/fwd1/fwd2 got %b want %b",
                         cyc, {iss_stall, iss_fire, fwd_rs1, fwd_rs2}, {e_stall, e_fire, e_f1, e_f2});
            end

            // Model state update.
            if (rst) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_cnt = 0;
                m_err = 1'b0;
                inflight.delete();
            end else begin
                if (retire && ((exu_wb_rd_addr != 0 && !m_pend[exu_wb_rd_addr]) || m_cnt == 0))
                    m_err = 1'b1;
                inc = e_fire && iss_long && (m_cnt < MAXO);
                dec = retire && (m_cnt > 0);
                m_cnt = m_cnt + int'(inc) - int'(dec);
                if (retire) m_pend[exu_wb_rd_addr] = 1'b0;
                if (e_fire && iss_long && iss_rd_wr_en && iss_rd_addr != 0)
                    m_pend[iss_rd_addr] = 1'b1;
                if (e_fire && iss_long) inflight.push_back(iss_rd_addr);
            end

            tick();

            e_vec = '0;
            for (int i = 1; i < 32; i++) e_vec[i] = m_pend[i];
            n_tests++;
            if (sb_pending !== e_vec || sb_outstanding !== 3'(m_cnt) || sb_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: pending %h count %0d err %b want %h/%0d/%b",
                         cyc, sb_pending, sb_outstanding, sb_err, e_vec, m_cnt, m_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_raw_mul();
        test_waw_setclr();
        test_capacity();
        test_x0_alu_bypass();
        test_errors();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idu1_scoreboard.md
# idu1_scoreboard

Register scoreboard for the IDU1 issue stage, directly upstream of the EXU. It tracks destination registers of in-flight multi-cycle operations (MUL, DIV, LSU, MAC) and stalls issue on RAW or WAW hazards against them. It retires entries from the EXU writeback port (`exu_wb_*`) and flags writeback bypass for operands whose producer writes back in the same cycle. It also caps the number of outstanding long operations.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum in-flight long operations; legal range 1..7.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `iss_valid`  in  1  IDU1 holds an instruction requesting issue.
- `iss_rs1_addr` / `iss_rs2_addr`  in  5  source register addresses.
- `iss_rs1_en` / `iss_rs2_en`  in  1  source operand is actually read.
- `iss_rd_addr`  in  5  destination address.
- `iss_rd_wr_en`  in  1  instruction writes rd.
- `iss_long`  in  1  instruction goes to MUL/DIV/LSU/MAC (multi-cycle writeback).
- `exu_wb_rd_addr`  in  5  EXU writeback address.
- `exu_wb_rd_wr_en`  in  1  EXU writeback valid.
- `exu_wb_long`  in  1  current writeback comes from MUL/DIV/LSU/MAC.
- `iss_stall`  out  1  hold the instruction in IDU1 this cycle.
- `iss_fire`  out  1  `iss_valid & ~iss_stall`.
- `fwd_rs1` / `fwd_rs2`  out  1  take the operand from `exu_wb_data` this cycle.
- `sb_pending`  out  32  per-register pending bits; bit 0 is always 0.
- `sb_outstanding`  out  3  count of in-flight long operations.
- `sb_err`  out  1  sticky protocol-error flag.

## Operation
- **Tracked issue.** An issue is tracked when `iss_fire & iss_long & iss_rd_wr_en & iss_rd_addr!=0`.
  - The next cycle, `pending[rd]` is 1.
- **Counted issue.** Every `iss_fire & iss_long` increments `sb_outstanding`, whether or not it is tracked.
- **Long retire.** A long retire is `exu_wb_rd_wr_en & exu_wb_long`.
  - It clears `pending[exu_wb_rd_addr]`.
  - It decrements `sb_outstanding`.
- **Long op with no rd write.** The EXU issues no writeback for it, so it never decrements the count. Therefore `iss_long` with `iss_rd_wr_en=0` is treated as a counted issue **only** when IDU1 guarantees a writeback. IDU1 must drive `iss_long=0` for long ops without rd.
- **Clear-this-cycle (`clr_hit(a)`).** True when `exu_wb_rd_wr_en & exu_wb_long & exu_wb_rd_addr==a`.
- **Stall conditions.** `iss_stall = iss_valid &` (any of the following):
  - RAW: `rsN_en & rsN!=0 & pending[rsN] & ~clr_hit(rsN)`, for N = 1, 2.
  - WAW: `iss_rd_wr_en & rd!=0 & pending[rd] & ~clr_hit(rd)`.
  - Full: `iss_long & sb_outstanding==MAX_OUTSTANDING`. A retire in the same cycle gives no relief.
- **Forwarding.** `fwd_rsN = iss_valid & rsN_en & rsN!=0 & exu_wb_rd_wr_en & exu_wb_rd_addr==rsN`.
  - This applies to ALU and long writebacks alike.
  - It is independent of stall.
- **Simultaneous set and clear of the same register.** Set wins: pending stays 1. The count is unchanged (+1 and -1).
- **Errors.** `sb_err` sets and stays set until reset when either occurs:
  - A long retire hits `exu_wb_rd_addr!=0` while `pending` is 0.
  - A long retire arrives with `sb_outstanding==0`. The count then holds at 0; no underflow.
- **Overflow guard.** No increment occurs past `MAX_OUTSTANDING`. This cannot occur legally, because the full condition stalls first.
- **Reset.**
  - `sb_pending`=0, `sb_outstanding`=0, `sb_err`=0.
  - Combinational outputs follow their equations: `iss_stall`, `iss_fire`, `fwd_*` are 0 when `iss_valid=0`.
  - Reset mid-operation discards all tracking. The EXU must be reset in the same cycle.

## Timing
- `sb_pending`, `sb_outstanding`, `sb_err` are registered and update on `clk` rising edge.
- `iss_stall`, `iss_fire`, `fwd_rs1`, `fwd_rs2` are combinational from registered state and same-cycle `iss_*` / `exu_wb_*`. There are no paths from outputs back to inputs.
- **Set latency:** fire in cycle N gives pending visible in N+1. A dependent instruction in N+1 stalls.
- **Clear latency:** a retire in cycle N unstalls a dependent instruction in N itself, with `fwd`=1. Pending is 0 from N+1.
- Stall has no hysteresis: it is re-evaluated every cycle.

## Test plan
- **Reset + idle.**
  - Stimulus: assert `rst` 2 cycles, then `iss_valid`=1, rs1=5, rd=6, `iss_long`=0.
  - Required: stall=0, fire=1, `sb_pending`=0, `sb_outstanding`=0.
- **RAW on MUL.**
  - Stimulus: fire long rd=7. Next cycle issue rs2=7.
  - Required: stall=1 each cycle until a long wb with addr=7. In that wb cycle: stall=0, `fwd_rs2`=1. Next cycle `pending[7]`=0.
- **WAW + same-cycle set/clear.**
  - Stimulus: `pending[9]`=1. Long wb addr 9 and long issue rd=9 in the same cycle.
  - Required: fire=1; `pending[9]` remains 1; `sb_outstanding` unchanged.
- **Capacity.**
  - Stimulus: `MAX_OUTSTANDING`=4. Fire 4 long ops rd=1..4, then a 5th long op rd=10.
  - Required: stall=1 even in the cycle of a retire. Fire in the cycle after the retire. Count goes 4→3→4.
- **x0 and ALU bypass.**
  - Stimulus 1: long issue rd=0. Required: pending unchanged, count+1.
  - Stimulus 2: ALU wb addr 3 (`exu_wb_long`=0) while issuing rs1=3. Required: `fwd_rs1`=1, stall=0.
- **Errors.**
  - Stimulus: long wb addr 12 with `pending[12]`=0.
  - Required: `sb_err`=1 next cycle and held; it clears only on `rst`.
